// File: rtl/key_evt_pkg.sv
// ----------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key event decoder: the FSM state encoding and
// the default timing constants, in clk cycles at 50 MHz.
// ----------------------------------------------------------------------------
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HOLD
    } key_state_e;

    localparam int unsigned CNT_W_DEF       = 26;
    localparam int unsigned LONG_CNT_DEF    = 49_999_999; // 1 s
    localparam int unsigned DBL_GAP_CNT_DEF = 14_999_999; // 300 ms
    localparam int unsigned REPEAT_CNT_DEF  = 9_999_999;  // 200 ms

endpackage

// File: rtl/key_evt_timer.sv
// ----------------------------------------------------------------------------
// key_evt_timer
// Saturating up-counter with an equality compare. One instance is shared by
// every state of the key event FSM, which selects the compare limit.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high (count -> 0)
//   i_clear   in   force count to 0 (wins over i_enable)
//   i_enable  in   count up by one; holds at all-ones instead of wrapping
//   i_limit   in   compare value
//   o_hit_eq  out  count == i_limit (combinational)
// ----------------------------------------------------------------------------
module key_evt_timer
    import key_evt_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_hit_eq
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_hit_eq = (r_count == i_limit);

endmodule

// File: rtl/key_event_decoder.sv
// ----------------------------------------------------------------------------
// key_event_decoder
// Classifies the debounced key level into short-press, long-press and
// double-click events, emitted as registered one-cycle strobes.
// Optional feature: define KEY_REPEAT_EN to emit repeat_pulse every
// REPEAT_CNT+1 cycles while the key is held past the long-press time.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   key_pressed   in   debounced key level, 1 = held
//   short_pulse   out  strobe: single short press
//   long_pulse    out  strobe: long press detected
//   double_pulse  out  strobe: double click
//   repeat_pulse  out  strobe: auto-repeat (constant 0 without KEY_REPEAT_EN)
//   busy          out  FSM not in IDLE
// ----------------------------------------------------------------------------
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned LONG_CNT    = LONG_CNT_DEF,
    parameter int unsigned DBL_GAP_CNT = DBL_GAP_CNT_DEF,
    parameter int unsigned REPEAT_CNT  = REPEAT_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(DBL_GAP_CNT);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CNT);

    key_state_e       r_state;
    logic             r_key_prev;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_busy;

    logic             w_rise;
    logic             w_fall;
    logic             w_hit;
    logic             w_clear;
    logic             w_enable;
    logic [CNT_W-1:0] w_limit;

    // key_prev resets to 1 so a key held through reset yields no rise.
    assign w_rise = key_pressed & ~r_key_prev;
    assign w_fall = ~key_pressed & r_key_prev;

    // The timer only ever compares against one limit per state.
    always_comb begin
        case (r_state)
            PRESS1:  w_limit = LONG_LIM;
            WAIT2:   w_limit = GAP_LIM;
            default: w_limit = REPEAT_LIM;
        endcase
    end

    // Timer runs only while a state is waiting on its limit; every exit
    // (edge or hit) clears it so the next state starts from 0.
    // NOTE: defaults assigned up front keep this block free of inferred latches.
    always_comb begin
        w_clear  = 1'b1;
        w_enable = 1'b0;
        case (r_state)
            PRESS1: begin
                if (!w_fall && !w_hit) begin
                    w_clear  = 1'b0;
                    w_enable = 1'b1;
                end
            end
            WAIT2: begin
                if (!w_rise && !w_hit) begin
                    w_clear  = 1'b0;
                    w_enable = 1'b1;
                end
            end
`ifdef KEY_REPEAT_EN
            LONG_HOLD: begin
                if (!w_fall && !w_hit) begin
                    w_clear  = 1'b0;
                    w_enable = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .i_limit  (w_limit),
        .o_hit_eq (w_hit)
    );

`ifdef KEY_REPEAT_EN
    logic r_repeat;
`endif

    // busy is updated alongside every state change so it always equals
    // (r_state != IDLE) without a decode after the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_key_prev <= 1'b1;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_double   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_repeat   <= 1'b0;
`endif
        end else begin
            r_key_prev <= key_pressed;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_double   <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_repeat   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESS1;
                        r_busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    // A release on the very cycle the limit is reached is
                    // still a short press.
                    if (w_fall) begin
                        r_state <= WAIT2;
                    end else if (w_hit) begin
                        r_state <= LONG_HOLD;
                        r_long  <= 1'b1;
                    end
                end
                WAIT2: begin
                    // The state is left at the gap limit, so any rise seen
                    // here is within the double-click window.
                    if (w_rise) begin
                        r_state <= PRESS2;
                    end else if (w_hit) begin
                        r_state <= IDLE;
                        r_short <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                PRESS2: begin
                    if (w_fall) begin
                        r_state  <= IDLE;
                        r_double <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                LONG_HOLD: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (w_hit) begin
                        r_repeat <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign double_pulse = r_double;
    assign busy         = r_busy;
`ifdef KEY_REPEAT_EN
    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// ----------------------------------------------------------------------------
// tb_key_event_decoder
// Directed stimulus with LONG_CNT=10, DBL_GAP_CNT=6, REPEAT_CNT=4. Expected
// strobes (kind + cycle) are queued when stimulus is issued; a negedge
// monitor pops and compares whenever any strobe is high.
// Cycle n is the interval after the n-th rising edge; inputs are driven
// 1 time unit after that edge and a strobe decided in cycle n shows in n+1.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_event_decoder;

    localparam logic [3:0] M_SHORT  = 4'b1000;
    localparam logic [3:0] M_LONG   = 4'b0100;
    localparam logic [3:0] M_DOUBLE = 4'b0010;
    localparam logic [3:0] M_REPEAT = 4'b0001;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_pressed = 1'b0;
    logic short_pulse, long_pulse, double_pulse, repeat_pulse, busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    key_event_decoder #(
        .CNT_W       (26),
        .LONG_CNT    (10),
        .DBL_GAP_CNT (6),
        .REPEAT_CNT  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pressed  (key_pressed),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .double_pulse (double_pulse),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input logic [3:0] mask, input int at);
        exp_t e;
        e.mask = mask;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            key_pressed = v;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [3:0] w;
        exp_t       e;
        w = {short_pulse, long_pulse, double_pulse, repeat_pulse};
        if (w != 4'b0000) begin
            check("one_strobe_per_cycle", $countones(w), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", int'(w), 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", int'(w), int'(e.mask));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int p;
        int r;

        // Reset state
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_outputs", int'({short_pulse, long_pulse, double_pulse, repeat_pulse}), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        drive(1'b0, 3);

        // 1. short press: strobe 8 cycles after release
        drive(1'b1, 3);
        check("busy_in_press", int'(busy), 1);
        r = cyc;
        expect_evt(M_SHORT, r + 8);
        drive(1'b0, 20);
        check("busy_after_short", int'(busy), 0);

        // 2. long press: strobe 12 cycles after rise, repeats every 5
        p = cyc;
        expect_evt(M_LONG, p + 12);
`ifdef KEY_REPEAT_EN
        expect_evt(M_REPEAT, p + 17);
        expect_evt(M_REPEAT, p + 22);
`endif
        drive(1'b1, 25);
        check("busy_long_hold", int'(busy), 1);
        drive(1'b0, 10);
        check("busy_after_long", int'(busy), 0);

        // 3. double click, gap 4
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 3);
        r = cyc;
        expect_evt(M_DOUBLE, r + 1);
        drive(1'b0, 12);

        // 3b. second rise exactly at timer == DBL_GAP_CNT still double
        drive(1'b1, 3);
        drive(1'b0, 7);
        drive(1'b1, 3);
        r = cyc;
        expect_evt(M_DOUBLE, r + 1);
        drive(1'b0, 12);

        // 4. gap past the window: two independent short presses
        drive(1'b1, 3);
        r = cyc;
        expect_evt(M_SHORT, r + 8);
        drive(1'b0, 8);
        drive(1'b1, 3);
        r = cyc;
        expect_evt(M_SHORT, r + 8);
        drive(1'b0, 12);

        // 4b. release on the cycle timer reaches LONG_CNT: fall wins
        drive(1'b1, 11);
        r = cyc;
        expect_evt(M_SHORT, r + 8);
        drive(1'b0, 12);

        // 4c. one cycle longer is a long press, release gives nothing more
        p = cyc;
        expect_evt(M_LONG, p + 12);
        drive(1'b1, 12);
        drive(1'b0, 12);

        // 5. key held through reset is ignored until released
        key_pressed = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(1'b1, 5);
        check("busy_held_through_reset", int'(busy), 0);
        drive(1'b0, 5);
        check("busy_after_held_release", int'(busy), 0);
        drive(1'b1, 3);
        r = cyc;
        expect_evt(M_SHORT, r + 8);
        drive(1'b0, 12);

        // 6. reset during WAIT2 aborts without a strobe
        drive(1'b1, 3);
        drive(1'b0, 2);
        check("busy_in_wait2", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_mid_reset", int'(busy), 0);
        rst = 1'b0;
        drive(1'b0, 12);
        drive(1'b1, 3);
        r = cyc;
        expect_evt(M_SHORT, r + 8);
        drive(1'b0, 12);

        check("pending_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
